fb_pixel_writer: RTL

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

---
 rtl/fb_pkg.sv | 27 ++
 rtl/fb_addr_counter.sv | 33 +++
 rtl/fb_pixel_writer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry, pixel type and the writer state enum.
// Build option FB_CLEAR_EN adds the CLEAR state (whole-frame fill).
package fb_pkg;

    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 17;
    localparam int FB_DATA_W = 12;

    typedef logic [FB_DATA_W-1:0] pixel_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1
`ifdef FB_CLEAR_EN
        , CLEAR = 2'd2
`endif
    } state_t;

    // Highest linear address of a frame holding 'pixels' pixels.
    function automatic fb_addr_t fb_last_addr(input int pixels);
        return fb_addr_t'(pixels - 1);
    endfunction

endpackage

// File: rtl/fb_addr_counter.sv
// fb_addr_counter: running raster address shared by the stream and clear paths.
// o_addr is the address used by this cycle's write (zero when restarting),
// o_last flags the final pixel of the frame.
module fb_addr_counter
    import fb_pkg::*;
#(
    parameter int PIXELS = FB_PIXELS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load_zero,
    input  logic                 i_inc,
    output logic [FB_ADDR_W-1:0] o_addr,
    output logic                 o_last
);

    localparam fb_addr_t LAST_ADDR = fb_last_addr(PIXELS);

    logic [FB_ADDR_W-1:0] r_cnt;

    assign o_addr = i_load_zero ? '0 : r_cnt;
    assign o_last = (o_addr == LAST_ADDR);

    // Restart at zero and/or step past the address just written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load_zero || i_inc) begin
            r_cnt <= o_addr + FB_ADDR_W'(i_inc);
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: turns a raster pixel stream into frame-buffer writes.
// Frames start only on s_sof; a mid-frame s_sof restarts at address 0 and
// raises the sticky resync flag. Define FB_CLEAR_EN to add the clear engine
// that fills the frame with clear_color.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int WIDTH  = FB_WIDTH,
    parameter int HEIGHT = FB_HEIGHT,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_sof,
    input  logic                 clear_req,
    input  logic [DATA_W-1:0]    clear_color,
    output logic                 we,
    output logic [FB_ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0]    wdata,
    output logic                 frame_done,
    output logic                 clear_done,
    output logic                 resync
);

    localparam int PIXELS = WIDTH * HEIGHT;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_ready;
    logic                 w_load_zero;
    logic                 w_inc;
    logic                 w_wr;
    logic [DATA_W-1:0]    w_wr_data;
    logic                 w_frame_last;
    logic                 w_set_resync;
    logic [FB_ADDR_W-1:0] w_addr;
    logic                 w_last;

    logic                 r_we;
    logic [FB_ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_frame_last;
    logic                 r_frame_done;
    logic                 r_resync;

`ifdef FB_CLEAR_EN
    logic                 w_clear_go;
    logic                 w_clear_start;
    logic                 w_clear_last;
    logic                 r_clear_pend;
    logic [DATA_W-1:0]    r_clear_color;
    logic                 r_clear_last;
    logic                 r_clear_done;

    assign w_clear_go = clear_req | r_clear_pend;
`endif

    fb_addr_counter #(
        .PIXELS      (PIXELS)
    ) u_addr (
        .clk         (clk),
        .rst         (rst),
        .i_load_zero (w_load_zero),
        .i_inc       (w_inc),
        .o_addr      (w_addr),
        .o_last      (w_last)
    );

    // Next state, handshake and write request for this cycle
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_load_zero  = 1'b0;
        w_inc        = 1'b0;
        w_wr         = 1'b0;
        w_wr_data    = s_data;
        w_frame_last = 1'b0;
        w_set_resync = 1'b0;
`ifdef FB_CLEAR_EN
        w_clear_start = 1'b0;
        w_clear_last  = 1'b0;
`endif
        case (r_state)
            IDLE: begin
`ifdef FB_CLEAR_EN
                if (w_clear_go) begin
                    w_clear_start = 1'b1;
                    w_load_zero   = 1'b1;
                    w_state_next  = CLEAR;
                end else
`endif
                begin
                    w_ready = 1'b1;
                    if (s_valid && s_sof) begin
                        w_load_zero  = 1'b1;
                        w_inc        = 1'b1;
                        w_wr         = 1'b1;
                        w_state_next = STREAM;
                    end
                end
            end
            STREAM: begin
                w_ready = 1'b1;
                if (s_valid) begin
                    w_load_zero  = s_sof;
                    w_inc        = 1'b1;
                    w_wr         = 1'b1;
                    w_set_resync = s_sof;
                    if (!s_sof && w_last) begin
                        w_frame_last = 1'b1;
                        w_state_next = IDLE;
                    end
                end
            end
`ifdef FB_CLEAR_EN
            CLEAR: begin
                w_inc     = 1'b1;
                w_wr      = 1'b1;
                w_wr_data = r_clear_color;
                if (w_last) begin
                    w_clear_last = 1'b1;
                    w_state_next = IDLE;
                end
            end
`endif
            default: w_state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Registered write port, frame completion pulse and sticky resync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_frame_last <= 1'b0;
            r_frame_done <= 1'b0;
            r_resync     <= 1'b0;
        end else begin
            r_we         <= w_wr;
            if (w_wr) begin
                r_waddr <= w_addr;
                r_wdata <= w_wr_data;
            end
            r_frame_last <= w_frame_last;
            r_frame_done <= r_frame_last;
            if (w_set_resync) r_resync <= 1'b1;
        end
    end

`ifdef FB_CLEAR_EN
    // Clear bookkeeping: queue requests seen mid-frame, latch fill colour, done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clear_pend  <= 1'b0;
            r_clear_color <= '0;
            r_clear_last  <= 1'b0;
            r_clear_done  <= 1'b0;
        end else begin
            if (w_clear_start) begin
                r_clear_pend  <= 1'b0;
                r_clear_color <= clear_color;
            end else if (r_state == STREAM && clear_req) begin
                r_clear_pend <= 1'b1;
            end
            r_clear_last <= w_clear_last;
            r_clear_done <= r_clear_last;
        end
    end

    assign clear_done = r_clear_done;
`else
    logic w_unused_clear;
    assign w_unused_clear = ^{clear_req, clear_color};
    assign clear_done     = 1'b0;
`endif

    assign s_ready    = w_ready & ~rst;
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign frame_done = r_frame_done;
    assign resync     = r_resync;

endmodule
